// File: rtl/knight_pkg.sv
// Shared constants and types for the KnightsTour remote-command link.
// Used by the command UART responder and its byte receiver.
package knight_pkg;

    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] NEG_ACK = 8'h5A;

    localparam int BAUD_CLKS_DEF = 2604;

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } asm_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: RX synchronizer, mid-bit sampling, start/stop check.
// o_rx_good pulses for one clock on the stop-bit sample of a clean frame.
module uart_rx_byte
    import knight_pkg::*;
#(
    parameter int BAUD_CLKS = BAUD_CLKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_good,
    output logic       o_rx_start,
    output logic       o_rx_busy
);

    localparam int CW = $clog2(BAUD_CLKS) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_CLKS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_CLKS - 1);

    rx_state_t     r_state;
    rx_state_t     w_next;
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_q;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_fall;
    logic          w_half;
    logic          w_full;

    assign w_fall    = r_rx_q & ~r_rx_s2;
    assign w_half    = (r_baud == HALF_M1);
    assign w_full    = (r_baud == FULL_M1);
    assign o_rx_data = r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_q  <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_q  <= r_rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RX_IDLE:  if (w_fall) w_next = RX_START;
            // A start bit that is high again at mid-bit was a glitch
            RX_START: if (w_half) w_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && r_bit == 3'd7) w_next = RX_STOP;
            RX_STOP:  if (w_full) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    always_comb begin
        o_rx_start = 1'b0;
        o_rx_good  = 1'b0;
        o_rx_busy  = 1'b1;
        unique case (r_state)
            RX_IDLE: begin
                o_rx_busy  = 1'b0;
                o_rx_start = w_fall;
            end
            RX_STOP: o_rx_good = w_full & r_rx_s2;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                end
                RX_START: r_baud <= w_half ? '0 : r_baud + 1'b1;
                default: begin
                    r_baud <= w_full ? '0 : r_baud + 1'b1;
                    if (w_full && r_state == RX_DATA) begin
                        r_shift <= {r_rx_s2, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/cmd_uart_responder.sv
// Remote-command UART endpoint: assembles two RX bytes into a 16-bit
// command with a ready/clear handshake and sends one response byte on TX.
module cmd_uart_responder
    import knight_pkg::*;
#(
    parameter int BAUD_CLKS    = BAUD_CLKS_DEF,
    parameter int TIMEOUT_CLKS = 2**20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int CW = $clog2(BAUD_CLKS) + 1;
    localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [CW-1:0] TX_FULL_M1 = CW'(BAUD_CLKS - 1);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CLKS);

    logic [7:0]    w_rx_data;
    logic          w_rx_good;
    logic          w_rx_start;
    logic          w_rx_busy;

    asm_state_t    r_asm;
    asm_state_t    w_asm_next;
    logic [15:0]   r_cmd;
    logic          r_cmd_rdy;
    logic [TW-1:0] r_tmo;
    logic          w_tmo_hit;
    logic          w_store_hi;
    logic          w_store_lo;
    logic          w_rdy_drop;

    logic          r_tx_busy;
    logic [9:0]    r_tx_shift;
    logic [CW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bits;
    logic          r_resp_sent;
    logic          w_tx_accept;
    logic          w_tx_bit_end;

    uart_rx_byte #(
        .BAUD_CLKS (BAUD_CLKS)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (RX),
        .o_rx_data  (w_rx_data),
        .o_rx_good  (w_rx_good),
        .o_rx_start (w_rx_start),
        .o_rx_busy  (w_rx_busy)
    );

    assign w_tmo_hit = (r_tmo == TMO_MAX);
    assign cmd       = r_cmd;
    assign cmd_rdy   = r_cmd_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm <= WAIT_HI;
        end else begin
            r_asm <= w_asm_next;
        end
    end

    always_comb begin
        w_asm_next = r_asm;
        unique case (r_asm)
            WAIT_HI: if (w_rx_good) w_asm_next = WAIT_LO;
            WAIT_LO: begin
                if (w_rx_good) begin
                    w_asm_next = WAIT_HI;
                end else if (w_tmo_hit && !w_rx_busy && !w_rx_start) begin
                    w_asm_next = WAIT_HI;
                end
            end
            default: w_asm_next = WAIT_HI;
        endcase
    end

    always_comb begin
        w_store_hi = 1'b0;
        w_store_lo = 1'b0;
        w_rdy_drop = 1'b0;
        unique case (r_asm)
            WAIT_HI: begin
                w_store_hi = w_rx_good;
                w_rdy_drop = w_rx_start;
            end
            WAIT_LO: w_store_lo = w_rx_good;
            default: ;
        endcase
    end

    // Timeout only runs while no low byte is being received
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_tmo     <= '0;
        end else begin
            if (w_store_hi) r_cmd[15:8] <= w_rx_data;
            if (w_store_lo) r_cmd[7:0]  <= w_rx_data;
            if (w_store_hi) begin
                r_tmo <= '0;
            end else if (r_asm == WAIT_LO && !w_rx_busy && !w_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_store_lo) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || w_rdy_drop) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign w_tx_accept  = send_resp & ~r_tx_busy;
    assign w_tx_bit_end = r_tx_busy && (r_tx_baud == TX_FULL_M1);
    assign TX           = r_tx_shift[0];
    assign resp_sent    = r_resp_sent;

    // Idle shifter holds all ones so TX rests high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_busy   <= 1'b0;
            r_tx_shift  <= '1;
            r_tx_baud   <= '0;
            r_tx_bits   <= '0;
            r_resp_sent <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_busy   <= 1'b1;
            r_tx_shift  <= {1'b1, resp, 1'b0};
            r_tx_baud   <= '0;
            r_tx_bits   <= '0;
            r_resp_sent <= 1'b0;
        end else if (r_tx_busy) begin
            if (w_tx_bit_end) begin
                r_tx_baud  <= '0;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_bits  <= r_tx_bits + 1'b1;
                if (r_tx_bits == 4'd9) begin
                    r_tx_busy   <= 1'b0;
                    r_resp_sent <= 1'b1;
                end
            end else begin
                r_tx_baud <= r_tx_baud + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_uart_responder.sv
// Bench for cmd_uart_responder: directed remote frames and responses,
// with scoreboard monitors on cmd_rdy and on the decoded TX line.
module tb_cmd_uart_responder;
    import knight_pkg::*;

    localparam int BAUD = 16;
    localparam int TMO  = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX;
    logic        cmd_rdy;
    logic        resp_sent;
    logic [15:0] cmd;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cmd[$];
    logic [7:0]  exp_tx[$];
    bit tx_abort = 1'b0;
    bit prev_rdy = 1'b0;

    cmd_uart_responder #(
        .BAUD_CLKS    (BAUD),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic send_cmd(input logic [15:0] w);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
        repeat (2 * BAUD) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && cmd_rdy === 1'b1 && !prev_rdy) begin
            if (exp_cmd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got %h expected none", cmd);
            end else begin
                check("cmd_scoreboard", cmd, exp_cmd.pop_front());
            end
        end
        prev_rdy = (cmd_rdy === 1'b1);
    end

    initial begin : tx_mon
        logic [7:0] b;
        logic       stp;
        forever begin
            @(negedge clk);
            if (!rst && TX === 1'b0) begin
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BAUD) @(negedge clk);
                stp = TX;
                if (tx_abort) begin
                    tx_abort = 1'b0;
                end else if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %h expected none", b);
                end else begin
                    check("tx_scoreboard", {7'd0, stp, b},
                          {7'd0, 1'b1, exp_tx.pop_front()});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (5) @(negedge clk);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
        check("rst_tx", 16'(TX), 16'h1);
        check("rst_resp_sent", 16'(resp_sent), 16'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        exp_cmd.push_back(16'h4002);
        send_cmd(16'h4002);
        check("cmd_4002", cmd, 16'h4002);
        check("rdy_4002", 16'(cmd_rdy), 16'h1);

        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("clr_rdy", 16'(cmd_rdy), 16'h0);
        check("cmd_hold", cmd, 16'h4002);

        exp_cmd.push_back(16'h4BF1);
        send_byte(8'h4B, 1'b1);
        clr_cmd_rdy = 1'b1;
        fork
            send_byte(8'hF1, 1'b1);
            begin
                k = 0;
                while (k < 12 * BAUD && cmd_rdy !== 1'b1) begin
                    @(negedge clk);
                    k++;
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        repeat (2 * BAUD) @(negedge clk);
        check("set_wins_rdy", 16'(cmd_rdy), 16'h1);
        check("cmd_4bf1", cmd, 16'h4BF1);

        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        send_byte(8'h47, 1'b1);
        repeat (TMO + 100) @(negedge clk);
        check("tmo_stale_cmd", cmd, 16'h47F1);
        check("tmo_no_rdy", 16'(cmd_rdy), 16'h0);
        exp_cmd.push_back(16'h43F1);
        send_cmd(16'h43F1);
        check("cmd_43f1", cmd, 16'h43F1);

        send_byte(8'h40, 1'b1);
        send_byte(8'h02, 1'b0);
        repeat (2 * BAUD) @(negedge clk);
        check("frm_no_rdy", 16'(cmd_rdy), 16'h0);
        check("frm_cmd", cmd, 16'h40F1);
        repeat (TMO + 100) @(negedge clk);
        exp_cmd.push_back(16'h6000);
        send_cmd(16'h6000);
        check("cmd_6000", cmd, 16'h6000);

        exp_tx.push_back(POS_ACK);
        resp = POS_ACK;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        resp = 8'h00;
        check("tx_start_bit", 16'(TX), 16'h0);
        check("tx_sent_low", 16'(resp_sent), 16'h0);
        repeat (60) @(negedge clk);
        resp = NEG_ACK;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        resp = 8'h00;
        repeat (98) @(negedge clk);
        check("tx_sent_pre", 16'(resp_sent), 16'h0);
        check("tx_stop_bit", 16'(TX), 16'h1);
        @(negedge clk);
        check("tx_sent_set", 16'(resp_sent), 16'h1);
        repeat (2 * BAUD) @(negedge clk);

        tx_abort = 1'b1;
        resp = POS_ACK;
        send_resp = 1'b1;
        RX = 1'b0;
        @(negedge clk);
        send_resp = 1'b0;
        check("tx_accept_clr", 16'(resp_sent), 16'h0);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        RX = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", 16'(TX), 16'h1);
        check("mid_rst_rdy", 16'(cmd_rdy), 16'h0);
        check("mid_rst_cmd", cmd, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        exp_cmd.push_back(16'h4002);
        send_cmd(16'h4002);
        check("post_rst_cmd", cmd, 16'h4002);
        check("post_rst_rdy", 16'(cmd_rdy), 16'h1);

        repeat (50) @(negedge clk);
        check("cmd_queue_left", 16'(exp_cmd.size()), 16'h0);
        check("tx_queue_left", 16'(exp_tx.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_uart_responder.md
Name: cmd_uart_responder

Overview:
DUT-side endpoint of the remote-command serial link. Receives two UART bytes from the remote (high byte first) and assembles them into a 16-bit command with a ready/clear handshake to the command processor. Transmits the single-byte response (ack/nack) back over TX. Sits between the RX/TX pins of KnightsTour and the command-processing FSM.

Parameters:
BAUD_CLKS, 2604, clocks per bit (50 MHz / 19200 baud); the counter is $clog2(BAUD_CLKS)+1 bits wide.
TIMEOUT_CLKS, 2**20, maximum clocks allowed from high-byte stop bit to low-byte start bit before resync.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
RX  in  1  serial input from remote, asynchronous, idle high
TX  out  1  serial output to remote, idle high
cmd  out  16  assembled command; {first byte, second byte}
cmd_rdy  out  1  new command valid
clr_cmd_rdy  in  1  processor consumed cmd
resp  in  8  response byte to send
send_resp  in  1  one-cycle pulse that starts transmission of resp
resp_sent  out  1  set when the stop bit completes; cleared by the next accepted send_resp

Behaviour:
- Reset values: cmd=16'h0000, cmd_rdy=0, TX=1, resp_sent=0. Internal state returns to IDLE. The RX synchronizer is preset to 1. Reset mid-frame aborts both directions immediately.
- RX path:
  - Double-flop synchronizer on RX.
  - A start is detected on the synchronized falling edge while the byte receiver is idle.
  - Data is sampled at BAUD_CLKS/2 into each bit. Frame is 1 start bit, 8 data bits LSB first, 1 stop bit.
  - Stop bit == 0 is a framing error: the byte is discarded and the assembly FSM is unaffected.
  - If the start bit reads 1 at mid-bit, the start is treated as a glitch and the receiver returns to idle.
- Assembly FSM:
  - States: WAIT_HI, WAIT_LO.
  - WAIT_HI, good byte: store it in cmd[15:8]; clear and start the timeout counter; go to WAIT_LO.
  - WAIT_LO, good byte: store it in cmd[7:0]; cmd_rdy<=1 on the cycle after the stop-bit sample; go to WAIT_HI. Latency is 1 clk after the stop-bit sample.
  - WAIT_LO, timeout counter reaches TIMEOUT_CLKS with no start bit: go to WAIT_HI. The partial byte is discarded, cmd[15:8] keeps the stale value, and cmd_rdy is not asserted.
- cmd_rdy handshake:
  - Stays high until clr_cmd_rdy, or until a new start bit is detected in WAIT_HI.
  - clr_cmd_rdy in the same cycle as a new completion: the set wins, so cmd_rdy stays 1.
  - cmd[7:0] must not change while cmd_rdy=1 unless a new frame is in progress.
- TX path:
  - send_resp while idle latches resp and shifts 10 bits LSB first at BAUD_CLKS per bit.
  - The start bit appears on TX the cycle after send_resp.
  - resp_sent is cleared on accept and set on the last clock of the stop bit.
  - send_resp while busy is ignored; the in-flight byte completes unchanged.
- RX and TX are fully independent (full duplex). Simultaneous activity in both directions is legal.

Decomposition:
- Shared package knight_pkg:
  - constants POS_ACK=8'hA5 and NEG_ACK=8'h5A;
  - default BAUD_CLKS;
  - typedef enum {WAIT_HI, WAIT_LO} asm_state_t.
- One sub-module, uart_rx_byte: synchronizer, start/stop check and sampling; outputs rx_data[7:0] and a one-cycle rx_good pulse.
- TX shifter stays inline in the top module.

Test Plan:
- Reset, then remote sends 16'h4002 (bytes 8'h40, 8'h02) -> cmd_rdy rises once with cmd=16'h4002; TX stays 1 throughout.
- Hold cmd_rdy, then pulse clr_cmd_rdy -> cmd_rdy=0 next clk. Then send 16'h4BF1 with clr_cmd_rdy held high during the low-byte completion cycle -> cmd_rdy=1, cmd=16'h4BF1.
- Send high byte 8'h47 only, wait TIMEOUT_CLKS+100, then send 16'h43F1 -> exactly one cmd_rdy, cmd=16'h43F1; no command ever appears with low byte 8'h43.
- Corrupt the stop bit of the second byte of 16'h4002 -> no cmd_rdy. A following clean 16'h6000 -> cmd=16'h6000.
- send_resp with resp=8'hA5 -> remote receives 8'hA5 after 10*BAUD_CLKS clks; resp_sent=1. A second send_resp with 8'h5A mid-frame -> ignored, only 8'hA5 received.
- Assert rst mid-RX byte and mid-TX byte -> TX=1 and cmd_rdy=0 next clk. A subsequent full command 16'h4002 is received correctly.
